// File: rtl/ro_seq_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
// ROSEQ_HEADER_EN adds a status header byte ahead of each 3-byte sum.
package ro_seq_pkg;

    localparam int         ACC_W     = 24;
    localparam logic [7:0] CMD_INV   = 8'h49;
    localparam logic [7:0] CMD_NAND  = 8'h4E;
    localparam logic [7:0] CMD_BOTH  = 8'h42;
    localparam logic [7:0] HDR_BASE  = 8'hA0;

`ifdef ROSEQ_HEADER_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

    // ST_SEND/ST_WAIT belong to the byte sender; the top treats ST_SEND as "frame in flight".
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT
    } seq_state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_INV) || (b == CMD_NAND) || (b == CMD_BOTH);
    endfunction

endpackage

// File: rtl/ro_measure_sequencer_if.sv
// UART and oscillator/counter signals of the measurement sequencer.
// master = sequencer side, slave = UART, oscillator mux and counter side.
interface ro_measure_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_clr;
    logic             osc_en;
    logic             osc_sel;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic             busy;

    modport master (
        input  rx_ready, rx_data, cnt_value, tx_busy,
        output cnt_clr, osc_en, osc_sel, tx_start, tx_data, busy
    );

    modport slave (
        output rx_ready, rx_data, cnt_value, tx_busy,
        input  cnt_clr, osc_en, osc_sel, tx_start, tx_data, busy
    );

endinterface

// File: rtl/ro_seq_byte_sender.sv
// Streams one measurement frame (optional header, then 24-bit word LSB first)
// through the UART transmitter handshake; pulses done after the last byte.
module ro_seq_byte_sender
    import ro_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] word,
`ifdef ROSEQ_HEADER_EN
    input  logic [7:0]       header,
`endif
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             done
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

    seq_state_t state;
    logic [1:0] idx;
    logic       guard;
    logic [7:0] cur_byte;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        cur_byte = 8'h00;
`ifdef ROSEQ_HEADER_EN
        case (idx)
            2'd0:    cur_byte = header;
            2'd1:    cur_byte = word[7:0];
            2'd2:    cur_byte = word[15:8];
            default: cur_byte = word[23:16];
        endcase
`else
        case (idx)
            2'd0:    cur_byte = word[7:0];
            2'd1:    cur_byte = word[15:8];
            default: cur_byte = word[23:16];
        endcase
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            guard    <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= cur_byte;
                        tx_start <= 1'b1;
                        guard    <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The UART raises tx_busy a cycle late, so the first WAIT cycle ignores it.
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!tx_busy) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ro_measure_sequencer.sv
// Command-driven ring-oscillator measurement sequencer: settle, gate, capture and
// accumulate 2^NSAMP_LOG2 windows, then send the sum. ROSEQ_HEADER_EN adds a header byte.
module ro_measure_sequencer
    import ro_seq_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter int NSAMP_LOG2    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ro_measure_sequencer_if.master  bus
);

    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int SIDX_W  = NSAMP_LOG2 + 1;

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [SIDX_W-1:0] SAMP_LAST   = SIDX_W'((1 << NSAMP_LOG2) - 1);

    seq_state_t        state;
    logic [TMR_W-1:0]  timer;
    logic [SIDX_W-1:0] sample_idx;
    logic [ACC_W-1:0]  acc;
    logic              sat;
    logic              both_pend;
    logic              snd_start;
    logic              snd_done;
    logic [CNT_W-1:0]  cnt_q;

    assign cnt_q = bus.cnt_value;

`ifdef ROSEQ_HEADER_EN
    logic [7:0] header;
    assign header = HDR_BASE | {6'b0, sat, bus.osc_sel};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            sample_idx  <= '0;
            acc         <= '0;
            sat         <= 1'b0;
            both_pend   <= 1'b0;
            snd_start   <= 1'b0;
            bus.osc_en  <= 1'b0;
            bus.osc_sel <= 1'b0;
            bus.cnt_clr <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            snd_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_ready && is_cmd(bus.rx_data)) begin
                        acc         <= '0;
                        sat         <= 1'b0;
                        sample_idx  <= '0;
                        timer       <= '0;
                        bus.osc_sel <= (bus.rx_data == CMD_NAND);
                        both_pend   <= (bus.rx_data == CMD_BOTH);
                        bus.osc_en  <= 1'b1;
                        bus.cnt_clr <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer       <= '0;
                        bus.cnt_clr <= 1'b0;
                        state       <= ST_GATE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_GATE: begin
                    if (timer == WINDOW_LAST) begin
                        timer      <= '0;
                        bus.osc_en <= 1'b0;
                        state      <= ST_CAPTURE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // First cycle lets the stopped counter settle; the second samples it.
                    if (timer == '0) begin
                        timer <= TMR_W'(1);
                    end else begin
                        timer <= '0;
                        acc   <= acc + ACC_W'(cnt_q);
                        sat   <= sat | (&cnt_q);
                        if (sample_idx == SAMP_LAST) begin
                            sample_idx <= '0;
                            snd_start  <= 1'b1;
                            state      <= ST_SEND;
                        end else begin
                            sample_idx  <= sample_idx + 1'b1;
                            bus.osc_en  <= 1'b1;
                            bus.cnt_clr <= 1'b1;
                            state       <= ST_SETTLE;
                        end
                    end
                end
                ST_SEND: begin
                    if (snd_done) begin
                        if (both_pend) begin
                            // Second half of 'B': switch to the NAND ring while it is still stopped.
                            both_pend   <= 1'b0;
                            bus.osc_sel <= 1'b1;
                            acc         <= '0;
                            sat         <= 1'b0;
                            bus.osc_en  <= 1'b1;
                            bus.cnt_clr <= 1'b1;
                            state       <= ST_SETTLE;
                        end else begin
                            bus.busy <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ro_seq_byte_sender u_sender (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (snd_start),
        .word     (acc),
`ifdef ROSEQ_HEADER_EN
        .header   (header),
`endif
        .tx_busy  (bus.tx_busy),
        .tx_start (bus.tx_start),
        .tx_data  (bus.tx_data),
        .done     (snd_done)
    );

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Directed bench for ro_measure_sequencer with a counter model and a UART model
// that holds tx_busy for 20 cycles starting one cycle after each tx_start.
module tb_ro_measure_sequencer;

`ifdef ROSEQ_HEADER_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif
    localparam int FRAME_LEN = 3 + HDR_N;

    logic clk;
    logic rst_n;
    logic hold_busy;
    int   total;
    int   bad;

    ro_measure_sequencer_if #(.CNT_W(16)) bus ();

    ro_measure_sequencer #(
        .WINDOW_CYCLES (10),
        .SETTLE_CYCLES (2),
        .CNT_W         (16),
        .NSAMP_LOG2    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter and UART models plus recorders.
    logic [15:0] win_vals [4];
    logic [7:0]  bytes [$];
    int          gates [$];
    logic        sels [$];
    int          win_idx;
    int          gate_cnt;
    int          busy_cnt;
    int          frames;
    int          consec_err;
    int          busy_err;
    logic        prev_en, prev_busy, prev_start;

    assign bus.tx_busy = (busy_cnt != 0) || hold_busy;

    initial begin
        win_idx = 0; gate_cnt = 0; busy_cnt = 0; frames = 0;
        consec_err = 0; busy_err = 0;
        prev_en = 1'b0; prev_busy = 1'b0; prev_start = 1'b0;
        bus.cnt_value = 16'h0;
    end

    always @(posedge clk) begin
        prev_en    <= bus.osc_en;
        prev_busy  <= bus.busy;
        prev_start <= bus.tx_start;
        if (bus.busy && !prev_busy) begin
            win_idx <= 0;
            bytes.delete();
            gates.delete();
            sels.delete();
            frames <= frames + 1;
        end
        if (bus.cnt_clr) begin
            bus.cnt_value <= 16'h0;
            gate_cnt      <= 0;
        end else if (bus.osc_en) begin
            gate_cnt <= gate_cnt + 1;
        end
        if (prev_en && !bus.osc_en) begin
            bus.cnt_value <= win_vals[win_idx % 4];
            win_idx       <= win_idx + 1;
            gates.push_back(gate_cnt);
            sels.push_back(bus.osc_sel);
        end
        if (bus.tx_start) begin
            bytes.push_back(bus.tx_data);
            busy_cnt <= 20;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (bus.tx_start && prev_start) consec_err <= consec_err + 1;
        if (bus.tx_start && bus.tx_busy) busy_err <= busy_err + 1;
    end

    function automatic logic [7:0] exp_byte(input logic [23:0] sum, input logic [7:0] hdr, input int k);
        if (k < HDR_N) return hdr;
        return sum[8*(k-HDR_N) +: 8];
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_vals(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        win_vals[0] = a; win_vals[1] = b; win_vals[2] = c; win_vals[3] = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.osc_en, bus.osc_sel, bus.cnt_clr, bus.tx_start, bus.busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus.osc_en, bus.osc_sel, bus.cnt_clr, bus.tx_start, bus.busy});
        end
        total++;
        if (bus.tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx_data got=%h want=00", bus.tx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_inverter;
        bit ok;
        set_vals(16'd100, 16'd101, 16'd102, 16'd103);
        send_cmd(8'h49);
        total++;
        if ({bus.busy, bus.osc_en, bus.cnt_clr, bus.osc_sel} !== 4'b1110) begin
            bad++;
            $display("FAIL inv_start got=%b want=1110", {bus.busy, bus.osc_en, bus.cnt_clr, bus.osc_sel});
        end
        wait_idle(2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL inv_timeout got=busy want=idle"); end
        total++;
        if (bus.tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL inv_busy_fall got=tx_busy %b want=0", bus.tx_busy);
        end
        total++;
        if (gates.size() != 4) begin
            bad++;
            $display("FAIL inv_windows got=%0d want=4", gates.size());
        end
        for (int k = 0; k < gates.size(); k++) begin
            total++;
            if (gates[k] != 10 || sels[k] !== 1'b0) begin
                bad++;
                $display("FAIL inv_gate%0d got=%0d/%b want=10/0", k, gates[k], sels[k]);
            end
        end
        total++;
        if (bytes.size() != FRAME_LEN) begin
            bad++;
            $display("FAIL inv_nbytes got=%0d want=%0d", bytes.size(), FRAME_LEN);
        end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] got;
            got = (k < bytes.size()) ? bytes[k] : 8'hxx;
            total++;
            if (got !== exp_byte(24'd406, 8'hA0, k)) begin
                bad++;
                $display("FAIL inv_byte%0d got=%h want=%h", k, got, exp_byte(24'd406, 8'hA0, k));
            end
        end
    endtask

    task automatic test_both;
        bit ok;
        set_vals(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        send_cmd(8'h42);
        wait_idle(4000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL both_timeout got=busy want=idle"); end
        total++;
        if (gates.size() != 8) begin
            bad++;
            $display("FAIL both_windows got=%0d want=8", gates.size());
        end
        for (int k = 0; k < sels.size(); k++) begin
            total++;
            if (sels[k] !== (k >= 4) || gates[k] != 10) begin
                bad++;
                $display("FAIL both_win%0d got=sel %b gate %0d want=sel %b gate 10",
                         k, sels[k], gates[k], (k >= 4));
            end
        end
        total++;
        if (bytes.size() != 2 * FRAME_LEN) begin
            bad++;
            $display("FAIL both_pulses got=%0d want=%0d", bytes.size(), 2 * FRAME_LEN);
        end
        for (int k = 0; k < 2 * FRAME_LEN; k++) begin
            logic [7:0] got, want;
            got  = (k < bytes.size()) ? bytes[k] : 8'hxx;
            want = (k < FRAME_LEN) ? exp_byte(24'h004000, 8'hA0, k)
                                   : exp_byte(24'h004000, 8'hA1, k - FRAME_LEN);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL both_byte%0d got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_ignored;
        bit ok;
        int f0;
        send_cmd(8'h41);
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_idle_bad_cmd got=%b want=0", bus.busy);
        end
        f0 = frames;
        set_vals(16'd1, 16'd2, 16'd3, 16'd4);
        send_cmd(8'h49);
        repeat (20) @(negedge clk);
        send_cmd(8'h41);
        repeat (5) @(negedge clk);
        send_cmd(8'h49);
        wait_idle(2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ign_timeout got=busy want=idle"); end
        repeat (40) @(negedge clk);
        total++;
        if (frames - f0 != 1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_frames got=%0d busy=%b want=1 busy=0", frames - f0, bus.busy);
        end
        total++;
        if (bytes.size() != FRAME_LEN) begin
            bad++;
            $display("FAIL ign_nbytes got=%0d want=%0d", bytes.size(), FRAME_LEN);
        end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] got;
            got = (k < bytes.size()) ? bytes[k] : 8'hxx;
            total++;
            if (got !== exp_byte(24'd10, 8'hA0, k)) begin
                bad++;
                $display("FAIL ign_byte%0d got=%h want=%h", k, got, exp_byte(24'd10, 8'hA0, k));
            end
        end
    endtask

    task automatic test_sat;
        bit ok;
        set_vals(16'hFFFF, 16'd1, 16'd1, 16'd1);
        send_cmd(8'h4E);
        wait_idle(2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL sat_timeout got=busy want=idle"); end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] got;
            got = (k < bytes.size()) ? bytes[k] : 8'hxx;
            total++;
            if (got !== exp_byte(24'h010002, 8'hA3, k)) begin
                bad++;
                $display("FAIL sat_byte%0d got=%h want=%h", k, got, exp_byte(24'h010002, 8'hA3, k));
            end
        end
        set_vals(16'd1, 16'd1, 16'd1, 16'd1);
        send_cmd(8'h4E);
        wait_idle(2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL sat2_timeout got=busy want=idle"); end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] got;
            got = (k < bytes.size()) ? bytes[k] : 8'hxx;
            total++;
            if (got !== exp_byte(24'd4, 8'hA1, k)) begin
                bad++;
                $display("FAIL sat2_byte%0d got=%h want=%h", k, got, exp_byte(24'd4, 8'hA1, k));
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        set_vals(16'd100, 16'd101, 16'd102, 16'd103);
        send_cmd(8'h49);
        n = 0;
        while (!(gates.size() == 1 && bus.osc_en && !bus.cnt_clr) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin bad++; $display("FAIL rmid_reach_gate got=timeout want=gate2"); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.osc_en, bus.busy, bus.tx_start, bus.cnt_clr} !== 4'b0) begin
            bad++;
            $display("FAIL rmid_async got=%b want=0000", {bus.osc_en, bus.busy, bus.tx_start, bus.cnt_clr});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        total++;
        if (bytes.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_no_tx got=%0d bytes busy=%b want=0 bytes busy=0", bytes.size(), bus.busy);
        end
        send_cmd(8'h49);
        wait_idle(2000, ok);
        total++;
        if (!ok || gates.size() != 4) begin
            bad++;
            $display("FAIL rmid_rerun got=ok %b windows %0d want=ok 1 windows 4", ok, gates.size());
        end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] got;
            got = (k < bytes.size()) ? bytes[k] : 8'hxx;
            total++;
            if (got !== exp_byte(24'd406, 8'hA0, k)) begin
                bad++;
                $display("FAIL rmid_byte%0d got=%h want=%h", k, got, exp_byte(24'd406, 8'hA0, k));
            end
        end
    endtask

    task automatic test_tx_hold;
        bit ok;
        int n;
        set_vals(16'd5, 16'd5, 16'd5, 16'd5);
        hold_busy = 1'b1;
        send_cmd(8'h49);
        n = 0;
        while (gates.size() < 4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 300) begin bad++; $display("FAIL hold_windows got=timeout want=4 windows"); end
        repeat (50) @(negedge clk);
        total++;
        if (bytes.size() != 0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_withheld got=%0d bytes busy=%b want=0 bytes busy=1", bytes.size(), bus.busy);
        end
        hold_busy = 1'b0;
        wait_idle(2000, ok);
        total++;
        if (!ok || bytes.size() != FRAME_LEN) begin
            bad++;
            $display("FAIL hold_pulses got=ok %b n %0d want=ok 1 n %0d", ok, bytes.size(), FRAME_LEN);
        end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] got;
            got = (k < bytes.size()) ? bytes[k] : 8'hxx;
            total++;
            if (got !== exp_byte(24'd20, 8'hA0, k)) begin
                bad++;
                $display("FAIL hold_byte%0d got=%h want=%h", k, got, exp_byte(24'd20, 8'hA0, k));
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        hold_busy = 1'b0;
        bus.rx_ready = 1'b0;
        bus.rx_data = 8'h00;
        set_vals(16'd0, 16'd0, 16'd0, 16'd0);
        test_reset;
        test_inverter;
        test_both;
        test_ignored;
        test_sat;
        test_reset_mid;
        test_tx_hold;
        total++;
        if (consec_err != 0 || busy_err != 0) begin
            bad++;
            $display("FAIL tx_protocol got=consec %0d while_busy %0d want=0 0", consec_err, busy_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
